// File: rtl/divider_sequencer.sv
// Restoring divider: one quotient bit per clock, sign fix-up, one-cycle done strobe; XLEN+2 cycles start-to-done, one cycle for divide-by-zero.
// Starts arriving while CALC/FIX run are dropped; define DIVSEQ_SIGNED_EN to honour signed_i.
module divider_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            dbz_o
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] dvd_q;   // shifts dividend out at the top, quotient in at the bottom
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [CW-1:0]   cnt_q;

    logic            accept;
    logic [XLEN:0]   partial;
    logic            fits;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] dvd_abs;
    logic [XLEN-1:0] dvs_abs;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

`ifdef DIVSEQ_SIGNED_EN
    logic sign_q_q;
    logic sign_r_q;
    logic dvd_neg;
    logic dvs_neg;

    assign dvd_neg = signed_i && dividend_i[XLEN-1];
    assign dvs_neg = signed_i && divisor_i[XLEN-1];
    assign dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_abs = dvs_neg ? -divisor_i : divisor_i;
    assign q_fix   = sign_q_q ? -dvd_q : dvd_q;
    assign r_fix   = sign_r_q ? -rem_q : rem_q;
`else
    logic signed_unused;

    assign signed_unused = signed_i;
    assign dvd_abs       = dividend_i;
    assign dvs_abs       = divisor_i;
    assign q_fix         = dvd_q;
    assign r_fix         = rem_q;
`endif

    assign accept  = start_i && (state == IDLE || state == DONE);
    assign partial = {rem_q, dvd_q[XLEN-1]};
    assign fits    = partial >= {1'b0, dvs_q};
    assign rem_sub = partial[XLEN-1:0] - dvs_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            dbz_o       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
`ifdef DIVSEQ_SIGNED_EN
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                CALC: begin
                    rem_q <= fits ? rem_sub : partial[XLEN-1:0];
                    dvd_q <= {dvd_q[XLEN-2:0], fits};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient_o  <= q_fix;
                    remainder_o <= r_fix;
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= DONE;
                end
                default: begin
                    if (accept) begin
                        dbz_o <= 1'b0;
                        if (divisor_i == '0) begin
                            // Divide-by-zero skips the datapath; result goes straight out.
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            dbz_o       <= 1'b1;
                            done_o      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_q  <= dvd_abs;
                            dvs_q  <= dvs_abs;
                            rem_q  <= '0;
                            cnt_q  <= CW'(XLEN - 1);
                            busy_o <= 1'b1;
                            state  <= CALC;
`ifdef DIVSEQ_SIGNED_EN
                            sign_q_q <= dvd_neg ^ dvs_neg;
                            sign_r_q <= dvd_neg;
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: directed cases plus randomized operands against an arithmetic model.
module tb_divider_sequencer;

    localparam int XLEN = 32;
`ifdef DIVSEQ_SIGNED_EN
    localparam bit SGN_BUILD = 1'b1;
`else
    localparam bit SGN_BUILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            signed_sel = 1'b0;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            dbz;

    divider_sequencer #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .signed_i    (signed_sel),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .dbz_o       (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic            dbz;
        int              due;
    } exp_t;

    exp_t exp_q[$];
    int   free_at = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, want);
    endtask

    function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s);
        exp_t e;
        logic [XLEN-1:0] ua, ub;
        e.due = 0;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else if (s && SGN_BUILD) begin
            ua = a[XLEN-1] ? -a : a;
            ub = b[XLEN-1] ? -b : b;
            e.q = ua / ub;
            e.r = ua % ub;
            if (a[XLEN-1] ^ b[XLEN-1]) e.q = -e.q;
            if (a[XLEN-1]) e.r = -e.r;
            e.dbz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle start; the model accepts it only once the previous op has reached its done cycle.
    task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s);
        exp_t e;
        start = 1'b1; dividend = a; divisor = b; signed_sel = s;
        if (cyc >= free_at) begin
            e = model(a, b, s);
            if (b == 0) begin
                e.due = cyc + 1;
            end else begin
                e.due   = cyc + XLEN + 2;
                busy_lo = cyc + 1;
                busy_hi = cyc + XLEN + 1;
            end
            free_at = e.due;
            exp_q.push_back(e);
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, XLEN'(busy), '0);
        chk({tag, "_done"}, XLEN'(done), '0);
        chk({tag, "_dbz"}, XLEN'(dbz), '0);
        chk({tag, "_quot"}, quotient, '0);
        chk({tag, "_rem"}, remainder, '0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", XLEN'(busy), XLEN'(cyc >= busy_lo && cyc <= busy_hi));
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", XLEN'(done), '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", XLEN'(cyc), XLEN'(e.due));
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("dbz", XLEN'(dbz), XLEN'(e.dbz));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("done_pulse", XLEN'(done), 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        logic [XLEN-1:0] a, b;

        tick(3);
        check_idle_zero("reset");
        reset = 1'b0;
        free_at = cyc;
        mon_en = 1'b1;

        issue(100, 7, 1'b0);
        tick(40);
        issue(5, 0, 1'b0);
        tick(5);
        issue(32'hFFFF_FFF9, 2, 1'b1);
        tick(40);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        tick(40);

        // Start during CALC is dropped; start in the done cycle is taken.
        k = cyc;
        issue(100, 7, 1'b0);
        tick(9);
        issue(9, 3, 1'b0);
        tick(k + XLEN + 2 - cyc);
        issue(9, 3, 1'b0);
        tick(40);

        // Reset mid-division, then a clean restart.
        k = cyc;
        issue(100, 7, 1'b0);
        tick(k + 15 - cyc);
        reset = 1'b1;
        exp_q.delete();
        busy_hi = cyc;
        tick(1);
        reset = 1'b0;
        free_at = cyc;
        check_idle_zero("midreset");
        issue(100, 7, 1'b0);
        tick(40);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: b = 0;
                1: b = '1;
                2: b = $urandom_range(1, 15);
                3: b = 1;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            issue(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0 && free_at > cyc) tick(free_at - cyc);
            else tick($urandom_range(0, 40));
        end
        tick(XLEN + 5);
        chk("queue_drained", XLEN'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
